tff_count_ctrl: RTL



---
 rtl/tff_ctrl_pkg.sv | 20 ++
 rtl/t_flipflop.sv | 21 ++
 rtl/tff_toggle_gen.sv | 33 +++
 rtl/tff_count_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T flip-flop counter controller.
// Controller states and the per-cycle toggle-generation mode.
package tff_ctrl_pkg;

    localparam int unsigned WidthMin = 2;
    localparam int unsigned WidthMax = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ModeHold = 2'b00,
        ModeStep = 2'b01,
        ModeLoad = 2'b10
    } mode_e;

endpackage

// File: rtl/t_flipflop.sv
// Single T flip-flop cell with synchronous active-high reset.
// On each clock edge, Q toggles when t is high.
module t_flipflop (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/tff_toggle_gen.sv
// Combinational toggle-vector generator for an array of T flip-flops.
// Produces the per-bit toggles for an up/down step, for a load of target, or for a hold.
module tff_toggle_gen
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] t
);

    logic run;

    always_comb begin
        t   = '0;
        run = 1'b1;
        unique case (mode)
            ModeStep: begin
                // A bit toggles when every lower bit is all-ones (up) or all-zeros (down).
                for (int i = 0; i < int'(WIDTH); i++) begin
                    t[i] = run;
                    run  = run & (up ? count[i] : ~count[i]);
                end
            end
            ModeLoad: t = count ^ target;
            default:  t = '0;
        endcase
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Programmable up/down counter built from T flip-flop cells.
// Supports load, terminal-count detection and one-shot or auto-reload modes.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             auto_reload,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_e           state_q, state_d;
    logic             tc_q, tc_d;
    mode_e            mode;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] qn_unused;
    logic             terminal;
    logic [WIDTH-1:0] reload_val;

    assign terminal   = up ? (q_vec == limit) : (q_vec == '0);
    assign reload_val = up ? '0 : limit;

    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        mode    = ModeHold;
        target  = '0;
        unique case (state_q)
            StIdle: begin
                if (load_en) begin
                    mode   = ModeLoad;
                    target = load_val;
                end
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (load_en) begin
                    mode   = ModeLoad;
                    target = load_val;
                end else if (en) begin
                    if (terminal) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            mode   = ModeLoad;
                            target = reload_val;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        mode = ModeStep;
                    end
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    // An explicit load takes precedence over the restart value.
                    if (load_en) begin
                        mode   = ModeLoad;
                        target = load_val;
                    end else if (start) begin
                        mode   = ModeLoad;
                        target = reload_val;
                    end
                    if (start) begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    tff_toggle_gen #(
        .WIDTH(WIDTH)
    ) u_toggle_gen (
        .count (q_vec),
        .up    (up),
        .mode  (mode),
        .target(target),
        .t     (toggle)
    );

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        t_flipflop u_cell (
            .clk(clk),
            .rst(rst),
            .t  (toggle[i]),
            .q  (q_vec[i]),
            .qn (qn_unused[i])
        );
    end

    assign count = q_vec;
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign tc    = tc_q;

endmodule
